// File: rtl/bsg_manycore_gs_writeback_pkg.sv
// rtl/bsg_manycore_gs_writeback_pkg.sv - shared types for the gather/scatter writeback stage
package bsg_manycore_gs_writeback_pkg;

   typedef enum logic [1:0] {
      eGSWB_idle,
      eGSWB_run,
      eGSWB_signal
   } gswb_state_e;

   // Non-zero payload written to the remote signal word on completion
   localparam int gswb_sig_data_lp = 1;

endpackage

// File: rtl/bsg_two_fifo.sv
// rtl/bsg_two_fifo.sv - two-entry registered FIFO with valid/ready in and valid/yumi out
module bsg_two_fifo #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] mem_r [2];
   logic               head_r, tail_r;
   logic [1:0]         count_r;
   logic               enq, deq;

   assign ready_o = (count_r != 2'd2);
   assign v_o     = (count_r != 2'd0);
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;
   assign data_o  = mem_r[head_r];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_r  <= 1'b0;
         tail_r  <= 1'b0;
         count_r <= 2'd0;
      end else begin
         if (enq) tail_r <= ~tail_r;
         if (deq) head_r <= ~head_r;
         count_r <= count_r + {1'b0, enq} - {1'b0, deq};
      end
   end

   // Storage needs no reset; v_o qualifies every read
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[tail_r] <= data_i;
   end

endmodule

// File: rtl/bsg_manycore_gs_writeback.sv
// rtl/bsg_manycore_gs_writeback.sv - writes returned remote loads to local dmem, then signals completion
module bsg_manycore_gs_writeback
   import bsg_manycore_gs_writeback_pkg::*;
#(
   parameter int  x_cord_width_p    = 4,
   parameter int  y_cord_width_p    = 4,
   parameter int  data_width_p      = 32,
   parameter int  addr_width_p      = 32,
   parameter int  load_id_width_p   = 11,
   parameter int  dmem_size_p       = 1024,
   localparam int mem_addr_width_lp = $clog2(dmem_size_p),
   localparam int count_width_lp    = $clog2(dmem_size_p + 1)
) (
   input  logic                         clk_i,
   input  logic                         reset_i,

   input  logic                         start_v_i,
   output logic                         start_ready_o,
   input  logic [mem_addr_width_lp-1:0] start_dst_addr_i,
   input  logic [count_width_lp-1:0]    start_words_i,
   input  logic [addr_width_p-1:0]      start_sig_addr_i,
   input  logic [x_cord_width_p-1:0]    start_sig_x_i,
   input  logic [y_cord_width_p-1:0]    start_sig_y_i,

   input  logic                         returned_v_i,
   input  logic [data_width_p-1:0]      returned_data_i,
   input  logic [load_id_width_p-1:0]   returned_load_id_i,
   output logic                         returned_yumi_o,

   output logic                         mem_v_o,
   output logic [mem_addr_width_lp-1:0] mem_addr_o,
   output logic [data_width_p-1:0]      mem_data_o,
   output logic [data_width_p/8-1:0]    mem_mask_o,
   input  logic                         mem_yumi_i,

   output logic                         sig_v_o,
   output logic [addr_width_p-1:0]      sig_addr_o,
   output logic [x_cord_width_p-1:0]    sig_x_cord_o,
   output logic [y_cord_width_p-1:0]    sig_y_cord_o,
   output logic [data_width_p-1:0]      sig_data_o,
   input  logic                         sig_ready_i,

   output logic                         busy_o,
   output logic                         done_o,
   output logic                         error_o
);

   localparam int fifo_width_lp = load_id_width_p + data_width_p;
   localparam int cmp_width_lp  = load_id_width_p + count_width_lp;

   gswb_state_e state_r, state_n;

   logic [mem_addr_width_lp-1:0] dst_r;
   logic [count_width_lp-1:0]    words_r, count_r, count_inc;
   logic [addr_width_p-1:0]      sig_addr_r;
   logic [x_cord_width_p-1:0]    sig_x_r;
   logic [y_cord_width_p-1:0]    sig_y_r;
   logic                         error_r, done_r, finish;

   logic                         in_run, start_take;
   logic                         fifo_ready, fifo_v, fifo_enq, fifo_deq, fifo_flush;
   logic [fifo_width_lp-1:0]     fifo_data;
   logic [load_id_width_p-1:0]   head_id;
   logic [data_width_p-1:0]      head_data;
   logic                         in_range, last, error_set;

   assign in_run     = (state_r == eGSWB_run);
   assign start_take = start_v_i & (state_r == eGSWB_idle);

   // Outside RUN returns are swallowed so the network never stalls behind us
   assign fifo_enq        = in_run & returned_v_i & fifo_ready;
   assign returned_yumi_o = in_run ? fifo_enq : returned_v_i;

   // Completion flushes the buffer so a stray extra return cannot leak into the next job
   assign fifo_flush = reset_i | last;

   bsg_two_fifo #(.width_p(fifo_width_lp)) return_fifo (
      .clk_i   (clk_i),
      .reset_i (fifo_flush),
      .ready_o (fifo_ready),
      .data_i  ({returned_load_id_i, returned_data_i}),
      .v_i     (fifo_enq),
      .v_o     (fifo_v),
      .data_o  (fifo_data),
      .yumi_i  (fifo_deq)
   );

   assign head_id   = fifo_data[fifo_width_lp-1 -: load_id_width_p];
   assign head_data = fifo_data[data_width_p-1:0];
   assign in_range  = cmp_width_lp'(head_id) < cmp_width_lp'(words_r);

   // Out-of-range heads retire immediately without touching memory
   assign fifo_deq  = in_run & fifo_v & (~in_range | mem_yumi_i);
   assign count_inc = count_r + count_width_lp'(1);
   assign last      = fifo_deq & (count_inc == words_r);

   assign error_set = (~in_run & returned_v_i)
                    | (fifo_deq & ~in_range)
                    | (last & (~fifo_ready | fifo_enq));

   assign mem_v_o    = in_run & fifo_v & in_range;
   assign mem_addr_o = mem_v_o ? dst_r + mem_addr_width_lp'(head_id) : '0;
   assign mem_data_o = mem_v_o ? head_data : '0;
   assign mem_mask_o = '1;

   assign sig_v_o      = (state_r == eGSWB_signal);
   assign sig_addr_o   = sig_addr_r;
   assign sig_x_cord_o = sig_x_r;
   assign sig_y_cord_o = sig_y_r;
   assign sig_data_o   = data_width_p'(gswb_sig_data_lp);

   assign start_ready_o = (state_r == eGSWB_idle);
   assign busy_o        = (state_r != eGSWB_idle);
   assign done_o        = done_r;
   assign error_o       = error_r;

   always_comb begin
      state_n = state_r;
      finish  = 1'b0;
      unique case (state_r)
         eGSWB_idle: begin
            if (start_v_i) begin
               if (start_words_i != '0)         state_n = eGSWB_run;
               else if (start_sig_addr_i != '0) state_n = eGSWB_signal;
               else                             finish  = 1'b1;
            end
         end
         eGSWB_run: begin
            if (last) begin
               if (sig_addr_r != '0) state_n = eGSWB_signal;
               else begin
                  state_n = eGSWB_idle;
                  finish  = 1'b1;
               end
            end
         end
         eGSWB_signal: begin
            if (sig_ready_i) begin
               state_n = eGSWB_idle;
               finish  = 1'b1;
            end
         end
         default: state_n = eGSWB_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= eGSWB_idle;
         dst_r      <= '0;
         words_r    <= '0;
         count_r    <= '0;
         sig_addr_r <= '0;
         sig_x_r    <= '0;
         sig_y_r    <= '0;
         error_r    <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r <= state_n;
         done_r  <= finish;
         if (start_take) begin
            dst_r      <= start_dst_addr_i;
            words_r    <= start_words_i;
            sig_addr_r <= start_sig_addr_i;
            sig_x_r    <= start_sig_x_i;
            sig_y_r    <= start_sig_y_i;
            count_r    <= '0;
         end else if (fifo_deq) begin
            count_r <= count_inc;
         end
         if (error_set)       error_r <= 1'b1;
         else if (start_take) error_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bsg_manycore_gs_writeback.sv
// tb/tb_bsg_manycore_gs_writeback.sv - directed vector bench for the gather/scatter writeback stage
module tb_bsg_manycore_gs_writeback;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        start_v_i, start_ready_o;
   logic [5:0]  start_dst_addr_i;
   logic [6:0]  start_words_i;
   logic [31:0] start_sig_addr_i;
   logic [3:0]  start_sig_x_i, start_sig_y_i;
   logic        returned_v_i, returned_yumi_o;
   logic [31:0] returned_data_i;
   logic [10:0] returned_load_id_i;
   logic        mem_v_o, mem_yumi_i;
   logic [5:0]  mem_addr_o;
   logic [31:0] mem_data_o;
   logic [3:0]  mem_mask_o;
   logic        sig_v_o, sig_ready_i;
   logic [31:0] sig_addr_o, sig_data_o;
   logic [3:0]  sig_x_cord_o, sig_y_cord_o;
   logic        busy_o, done_o, error_o;

   always #5 clk = ~clk;

   bsg_manycore_gs_writeback #(
      .x_cord_width_p(4), .y_cord_width_p(4), .data_width_p(32),
      .addr_width_p(32), .load_id_width_p(11), .dmem_size_p(64)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .start_v_i(start_v_i), .start_ready_o(start_ready_o),
      .start_dst_addr_i(start_dst_addr_i), .start_words_i(start_words_i),
      .start_sig_addr_i(start_sig_addr_i), .start_sig_x_i(start_sig_x_i),
      .start_sig_y_i(start_sig_y_i),
      .returned_v_i(returned_v_i), .returned_data_i(returned_data_i),
      .returned_load_id_i(returned_load_id_i), .returned_yumi_o(returned_yumi_o),
      .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_mask_o(mem_mask_o), .mem_yumi_i(mem_yumi_i),
      .sig_v_o(sig_v_o), .sig_addr_o(sig_addr_o), .sig_x_cord_o(sig_x_cord_o),
      .sig_y_cord_o(sig_y_cord_o), .sig_data_o(sig_data_o), .sig_ready_i(sig_ready_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
   );

   typedef struct {
      logic [5:0]  dst;
      logic [6:0]  words;
      logic [31:0] sig;
      logic [3:0]  x;
      logic [3:0]  y;
      logic        exp_err;
   } job_t;

   typedef struct {
      logic [10:0] id;
      logic [31:0] data;
      logic        wr;
      logic [5:0]  addr;
   } ret_t;

   job_t jobs [4];
   ret_t rets [16];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_job(input logic [5:0] dst, input logic [6:0] words,
                            input logic [31:0] sig, input logic [3:0] x, input logic [3:0] y);
      @(negedge clk);
      start_v_i = 1'b1;
      start_dst_addr_i = dst;
      start_words_i = words;
      start_sig_addr_i = sig;
      start_sig_x_i = x;
      start_sig_y_i = y;
      #1 check("start_ready", start_ready_o, 1);
      @(negedge clk);
      start_v_i = 1'b0;
   endtask

   task automatic send_one(input logic [10:0] id, input logic [31:0] data,
                           input logic wr, input logic [5:0] addr);
      returned_v_i = 1'b1;
      returned_load_id_i = id;
      returned_data_i = data;
      #1 check("ret_yumi", returned_yumi_o, 1);
      @(negedge clk);
      returned_v_i = 1'b0;
      check("mem_v", mem_v_o, wr);
      if (wr) begin
         check("mem_addr", mem_addr_o, addr);
         check("mem_data", mem_data_o, data);
         check("mem_mask", mem_mask_o, 4'hF);
      end
      mem_yumi_i = 1'b1;
      @(negedge clk);
      mem_yumi_i = 1'b0;
   endtask

   task automatic run_job(input int j);
      job_t jb;
      ret_t r;
      jb = jobs[j];
      start_job(jb.dst, jb.words, jb.sig, jb.x, jb.y);
      check("busy_run", busy_o, 1);
      check("err_cleared", error_o, 0);
      for (int k = 0; k < 4; k++) begin
         r = rets[j*4 + k];
         send_one(r.id, r.data, r.wr, r.addr);
      end
      check("sig_v", sig_v_o, 1);
      check("sig_addr", sig_addr_o, jb.sig);
      check("sig_x", sig_x_cord_o, jb.x);
      check("sig_y", sig_y_cord_o, jb.y);
      check("sig_data", sig_data_o, 1);
      check("err_job", error_o, jb.exp_err);
      check("done_early", done_o, 0);
      @(negedge clk);
      check("sig_hold", sig_v_o, 1);
      check("sig_addr_hold", sig_addr_o, jb.sig);
      sig_ready_i = 1'b1;
      @(negedge clk);
      sig_ready_i = 1'b0;
      check("done_pulse", done_o, 1);
      check("ready_after_sig", start_ready_o, 1);
      check("sig_v_off", sig_v_o, 0);
      @(negedge clk);
      check("done_one_cycle", done_o, 0);
   endtask

   logic [37:0] got [$];
   int          idx;
   bit          seen_done;

   initial begin
      jobs[0] = '{6'h10, 7'd4, 32'h200, 4'd1, 4'd2, 1'b0};
      jobs[1] = '{6'h20, 7'd4, 32'h204, 4'd3, 4'd0, 1'b0};
      jobs[2] = '{6'd62, 7'd4, 32'h300, 4'd2, 4'd3, 1'b0};
      jobs[3] = '{6'h30, 7'd4, 32'h308, 4'd0, 4'd1, 1'b1};
      rets[0]  = '{11'd0, 32'hA0, 1'b1, 6'h10};
      rets[1]  = '{11'd1, 32'hA1, 1'b1, 6'h11};
      rets[2]  = '{11'd2, 32'hA2, 1'b1, 6'h12};
      rets[3]  = '{11'd3, 32'hA3, 1'b1, 6'h13};
      rets[4]  = '{11'd3, 32'hB3, 1'b1, 6'h23};
      rets[5]  = '{11'd0, 32'hB0, 1'b1, 6'h20};
      rets[6]  = '{11'd2, 32'hB2, 1'b1, 6'h22};
      rets[7]  = '{11'd1, 32'hB1, 1'b1, 6'h21};
      rets[8]  = '{11'd0, 32'hC0, 1'b1, 6'd62};
      rets[9]  = '{11'd1, 32'hC1, 1'b1, 6'd63};
      rets[10] = '{11'd2, 32'hC2, 1'b1, 6'd0};
      rets[11] = '{11'd3, 32'hC3, 1'b1, 6'd1};
      rets[12] = '{11'd0, 32'hD0, 1'b1, 6'h30};
      rets[13] = '{11'd7, 32'hD7, 1'b0, 6'h00};
      rets[14] = '{11'd2, 32'hD2, 1'b1, 6'h32};
      rets[15] = '{11'd1, 32'hD1, 1'b1, 6'h31};

      reset_i = 1'b1;
      start_v_i = 1'b0;
      start_dst_addr_i = '0;
      start_words_i = '0;
      start_sig_addr_i = '0;
      start_sig_x_i = '0;
      start_sig_y_i = '0;
      returned_v_i = 1'b0;
      returned_data_i = '0;
      returned_load_id_i = '0;
      mem_yumi_i = 1'b0;
      sig_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;

      check("rst_start_ready", start_ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_mem_v", mem_v_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_mem_data", mem_data_o, 0);
      check("rst_mem_mask", mem_mask_o, 4'hF);
      check("rst_sig_v", sig_v_o, 0);
      check("rst_sig_addr", sig_addr_o, 0);
      check("rst_sig_data", sig_data_o, 1);
      check("rst_done", done_o, 0);
      check("rst_error", error_o, 0);
      check("rst_yumi", returned_yumi_o, 0);

      for (int j = 0; j < 4; j++) run_job(j);

      start_job(6'h05, 7'd0, 32'h0, 4'd0, 4'd0);
      check("zero_done", done_o, 1);
      check("zero_idle", busy_o, 0);
      check("zero_sig_v", sig_v_o, 0);
      check("zero_mem_v", mem_v_o, 0);
      @(negedge clk);
      check("zero_done_off", done_o, 0);

      returned_v_i = 1'b1;
      returned_load_id_i = 11'd3;
      returned_data_i = 32'h55;
      #1 check("idle_ret_yumi", returned_yumi_o, 1);
      @(negedge clk);
      returned_v_i = 1'b0;
      check("idle_ret_err", error_o, 1);
      check("idle_ret_mem_v", mem_v_o, 0);

      start_job(6'h08, 7'd4, 32'h0, 4'd0, 4'd0);
      idx = 0;
      seen_done = 1'b0;
      got.delete();
      for (int c = 0; c < 40 && !seen_done; c++) begin
         if (c > 0) @(negedge clk);
         if (done_o) seen_done = 1'b1;
         mem_yumi_i = (c >= 6);
         returned_v_i = (idx < 4);
         returned_load_id_i = 11'(idx);
         returned_data_i = 32'(32'hE0 + idx);
         #1;
         if (c == 2 || c == 4) check("bp_full_yumi", returned_yumi_o, 0);
         if (c == 4) begin
            check("bp_head_addr", mem_addr_o, 6'h08);
            check("bp_head_data", mem_data_o, 32'hE0);
         end
         if (mem_v_o && mem_yumi_i) got.push_back({mem_addr_o, mem_data_o});
         if (returned_v_i && returned_yumi_o) idx++;
      end
      returned_v_i = 1'b0;
      mem_yumi_i = 1'b0;
      check("bp_done_seen", seen_done, 1);
      check("bp_write_count", got.size(), 4);
      for (int i = 0; i < got.size(); i++)
         check("bp_write", got[i], {6'(8 + i), 32'(32'hE0 + i)});
      check("bp_error", error_o, 0);

      start_job(6'h00, 7'd4, 32'h400, 4'd1, 4'd1);
      send_one(11'd0, 32'hF0, 1'b1, 6'h00);
      send_one(11'd1, 32'hF1, 1'b1, 6'h01);
      send_one(11'd9, 32'hF9, 1'b0, 6'h00);
      check("rst_pre_err", error_o, 1);
      returned_v_i = 1'b1;
      returned_load_id_i = 11'd2;
      returned_data_i = 32'hF2;
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      returned_v_i = 1'b0;
      check("mid_rst_ready", start_ready_o, 1);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_mem_v", mem_v_o, 0);
      check("mid_rst_sig_v", sig_v_o, 0);
      check("mid_rst_done", done_o, 0);
      check("mid_rst_err", error_o, 0);
      @(negedge clk);
      check("mid_rst_no_done", done_o, 0);

      run_job(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
